// File: rtl/uart_pkg.sv
// Shared UART definitions used by the receiver, transmitter and receive buffer.
package uart_pkg;

  localparam int UART_BYTE_W    = 8;
  localparam int CLKS_PER_BIT_W = 16;

  typedef logic [UART_BYTE_W-1:0]    uart_byte_t;
  typedef logic [CLKS_PER_BIT_W-1:0] clks_per_bit_t;

  // True when a prescaler value has reached the end of one bit-time.
  // Divisors of 0 and 1 both mean "one bit-time per clock".
  function automatic logic bit_terminal(input clks_per_bit_t presc, input clks_per_bit_t divisor);
    bit_terminal = (divisor <= clks_per_bit_t'(1)) || (presc >= divisor - clks_per_bit_t'(1));
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-time timer: a prescaler that divides clk by clks_per_bit_i into
// bit ticks, followed by a saturating count of elapsed bit-times.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      restart_i,
  input  logic                      enable_i,
  input  logic [CLKS_PER_BIT_W-1:0] clks_per_bit_i,
  output logic                      bit_tick_o,
  output logic [CNT_W-1:0]          bit_count_o
);

  clks_per_bit_t presc;

  // A tick fires on the terminal prescaler count. Comparing with >= lets a
  // divisor that shrinks mid-count end the current bit at the next compare.
  always_comb begin
    bit_tick_o = enable_i && !restart_i && bit_terminal(presc, clks_per_bit_i);
  end

  // Prescaler: counts 0..clks_per_bit_i-1, held at 0 while restarting.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: sequential state is only ever assigned with <=, so every flop
    // samples the pre-edge value of every other flop.
    if (!rst_ni) begin
      presc <= '0;
    end else if (restart_i || !enable_i || bit_tick_o) begin
      presc <= '0;
    end else begin
      presc <= presc + clks_per_bit_t'(1);
    end
  end

  // Bit-time counter: one step per tick, sticks at all-ones.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bit_count_o <= '0;
    end else if (restart_i) begin
      bit_count_o <= '0;
    end else if (bit_tick_o && (bit_count_o != '1)) begin
      bit_count_o <= bit_count_o + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: captures received bytes into a flop FIFO and offers
// them on a first-word-fall-through valid/ready port, with overrun,
// watermark and character-timeout flags for the interrupt logic.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter  int DEPTH        = 16,
  parameter  int TIMEOUT_BITS = 32,
  localparam int AW           = $clog2(DEPTH)
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      rx_dv_i,
  input  logic [UART_BYTE_W-1:0]    rx_byte_i,
  input  logic [CLKS_PER_BIT_W-1:0] clks_per_bit_i,
  input  logic                      clr_i,
  input  logic                      clr_ovr_i,
  input  logic [AW:0]               wm_level_i,
  input  logic                      rd_ready_i,
  output logic                      rd_valid_o,
  output logic [UART_BYTE_W-1:0]    rd_data_o,
  output logic [AW:0]               level_o,
  output logic                      wm_o,
  output logic                      overrun_o,
  output logic                      timeout_o
);

  localparam logic [15:0] TIMEOUT_FULL = 16'(TIMEOUT_BITS);
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_BITS - 1);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]  wptr;
  logic [AW:0]  rptr;
  uart_byte_t   mem [DEPTH];

  logic         empty;
  logic         full;
  logic         push;
  logic         pop;
  logic         drop;
  logic         timer_restart;
  logic         bit_tick;
  logic [15:0]  bit_count;
  logic         timeout_hit;

  // Occupancy and handshake decode, all from registered state except the
  // push/pop qualifiers, which never feed an output.
  always_comb begin
    empty   = (wptr == rptr);
    full    = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
    pop     = !clr_i && !empty && rd_ready_i;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    push    = !clr_i && rx_dv_i && (!full || pop);
    drop    = !clr_i && rx_dv_i && full && !pop;
    timer_restart = push || pop || clr_i || empty;
    timeout_hit   = !empty && ((bit_count >= TIMEOUT_FULL) ||
                               (bit_tick && (bit_count == TIMEOUT_LAST)));
  end

  // Read-side outputs; the head byte reads as 0 whenever nothing is stored.
  always_comb begin
    rd_valid_o = !empty;
    rd_data_o  = empty ? '0 : mem[rptr[AW-1:0]];
    level_o    = wptr - rptr;
    wm_o       = (wm_level_i != '0) && (level_o >= wm_level_i);
  end

  // Pointer update; flush overrides any coincident push or pop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr <= '0;
      rptr <= '0;
    end else if (clr_i) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + (AW+1)'(1);
      if (pop)  rptr <= rptr + (AW+1)'(1);
    end
  end

  // Byte storage, written at the write pointer on every accepted push.
  // NOTE: the array has no reset; stale entries are unreachable because the
  // pointers are reset and the read mux is forced to 0 while empty.
  always_ff @(posedge clk_i) begin
    if (push) mem[wptr[AW-1:0]] <= rx_byte_i;
  end

  // Sticky overrun: flush clears, a fresh drop beats a coincident clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      overrun_o <= 1'b0;
    end else if (clr_i) begin
      overrun_o <= 1'b0;
    end else if (drop) begin
      overrun_o <= 1'b1;
    end else if (clr_ovr_i) begin
      overrun_o <= 1'b0;
    end
  end

  // Character timeout: set once the quiet period completes with data
  // waiting, held until the next push, pop or flush.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      timeout_o <= 1'b0;
    end else if (clr_i || push || pop) begin
      timeout_o <= 1'b0;
    end else if (timeout_hit) begin
      timeout_o <= 1'b1;
    end
  end

  uart_bit_timer #(
    .CNT_W (16)
  ) u_bit_timer (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .restart_i      (timer_restart),
    .enable_i       (!empty),
    .clks_per_bit_i (clks_per_bit_i),
    .bit_tick_o     (bit_tick),
    .bit_count_o    (bit_count)
  );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: a byte queue models the FIFO
// contents; bytes are queued when accepted and compared when read.
module tb_uart_rx_fifo;

  localparam int DEPTH = 16;
  localparam int AW    = $clog2(DEPTH);

  logic          clk;
  logic          rst_n;
  logic          rx_dv;
  logic [7:0]    rx_byte;
  logic [15:0]   clks_per_bit;
  logic          clr;
  logic          clr_ovr;
  logic [AW:0]   wm_level;
  logic          rd_ready;
  logic          rd_valid;
  logic [7:0]    rd_data;
  logic [AW:0]   level;
  logic          wm;
  logic          overrun;
  logic          timeout;

  int            checks;
  int            errors;
  logic [7:0]    sb [$];

  uart_rx_fifo #(
    .DEPTH        (DEPTH),
    .TIMEOUT_BITS (32)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .rx_dv_i        (rx_dv),
    .rx_byte_i      (rx_byte),
    .clks_per_bit_i (clks_per_bit),
    .clr_i          (clr),
    .clr_ovr_i      (clr_ovr),
    .wm_level_i     (wm_level),
    .rd_ready_i     (rd_ready),
    .rd_valid_o     (rd_valid),
    .rd_data_o      (rd_data),
    .level_o        (level),
    .wm_o           (wm),
    .overrun_o      (overrun),
    .timeout_o      (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One accepted or dropped byte; the scoreboard only keeps accepted ones.
  task automatic push(input logic [7:0] b);
    rx_dv   = 1'b1;
    rx_byte = b;
    if (sb.size() < DEPTH) sb.push_back(b);
    tick();
    rx_dv   = 1'b0;
  endtask

  // Pop one byte, comparing the head against the scoreboard first.
  task automatic pop_check(input string name);
    logic [7:0] exp;
    exp = sb.pop_front();
    rd_ready = 1'b1;
    checks++;
    if (rd_data !== exp || rd_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s: data=%h valid=%b, want data=%h valid=1", name, rd_data, rd_valid, exp);
    end
    tick();
    rd_ready = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (rd_valid !== 1'b0 || rd_data !== 8'h00 || level !== '0 || wm !== 1'b0 ||
        overrun !== 1'b0 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL reset: valid=%b data=%h level=%0d wm=%b ovr=%b to=%b, want all 0",
               rd_valid, rd_data, level, wm, overrun, timeout);
    end
  endtask

  task automatic test_basic();
    push(8'h55);
    push(8'hAA);
    push(8'h0F);
    checks++;
    if (level !== 5'd3 || rd_data !== 8'h55) begin
      errors++;
      $display("FAIL basic_fill: level=%0d head=%h, want 3 55", level, rd_data);
    end
    pop_check("basic_read0");
    pop_check("basic_read1");
    pop_check("basic_read2");
    checks++;
    if (rd_valid !== 1'b0 || level !== '0) begin
      errors++;
      $display("FAIL basic_empty: valid=%b level=%0d, want 0 0", rd_valid, level);
    end
  endtask

  task automatic test_overrun();
    for (int i = 0; i < DEPTH; i++) push(8'(i * 7 + 3));
    checks++;
    if (level !== 5'd16 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL ovr_fill: level=%0d ovr=%b, want 16 0", level, overrun);
    end
    push(8'h99);
    checks++;
    if (overrun !== 1'b1 || level !== 5'd16 || rd_data !== sb[0]) begin
      errors++;
      $display("FAIL ovr_drop: ovr=%b level=%0d head=%h, want 1 16 %h", overrun, level, rd_data, sb[0]);
    end
    clr_ovr = 1'b1;
    tick();
    clr_ovr = 1'b0;
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL ovr_clear: ovr=%b, want 0", overrun);
    end
    // A drop coinciding with the clear request leaves the flag set.
    clr_ovr = 1'b1;
    push(8'h77);
    clr_ovr = 1'b0;
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL ovr_set_wins: ovr=%b, want 1", overrun);
    end
    clr_ovr = 1'b1;
    tick();
    clr_ovr = 1'b0;
  endtask

  task automatic test_full_push_pop();
    logic [7:0] exp;
    exp      = sb.pop_front();
    sb.push_back(8'hC3);
    rx_dv    = 1'b1;
    rx_byte  = 8'hC3;
    rd_ready = 1'b1;
    checks++;
    if (rd_data !== exp) begin
      errors++;
      $display("FAIL full_pp_head: data=%h, want %h", rd_data, exp);
    end
    tick();
    rx_dv    = 1'b0;
    rd_ready = 1'b0;
    checks++;
    if (level !== 5'd16 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL full_pp: level=%0d ovr=%b, want 16 0", level, overrun);
    end
    while (sb.size() > 0) pop_check("full_pp_drain");
    checks++;
    if (level !== '0 || rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL full_pp_empty: level=%0d valid=%b, want 0 0", level, rd_valid);
    end
  endtask

  task automatic test_timeout();
    int n;
    logic seen;
    clks_per_bit = 16'd4;
    tick();
    push(8'h42);
    checks++;
    if (timeout !== 1'b0) begin
      errors++;
      $display("FAIL to_early: timeout=%b right after push, want 0", timeout);
    end
    n = 0;
    while (timeout !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
    checks++;
    if (n < 127 || n > 129) begin
      errors++;
      $display("FAIL to_delay: rose after %0d cycles, want 128 (+/-1)", n);
    end
    pop_check("to_pop");
    checks++;
    if (timeout !== 1'b0) begin
      errors++;
      $display("FAIL to_clear: timeout=%b after pop, want 0", timeout);
    end
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (timeout !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL to_empty: timeout asserted while empty=%b, want 0", seen);
    end
    clks_per_bit = 16'd16;
  endtask

  task automatic test_watermark();
    wm_level = 5'd4;
    for (int i = 1; i <= 4; i++) begin
      push(8'(8'h10 + i));
      checks++;
      if (wm !== (i >= 4)) begin
        errors++;
        $display("FAIL wm_push%0d: wm=%b, want %b", i, wm, (i >= 4));
      end
    end
    wm_level = '0;
    #1;
    checks++;
    if (wm !== 1'b0) begin
      errors++;
      $display("FAIL wm_disabled: wm=%b at level %0d, want 0", wm, level);
    end
    while (sb.size() > 0) pop_check("wm_drain");
  endtask

  task automatic test_clr();
    for (int i = 0; i < 5; i++) push(8'(8'hA0 + i));
    clr      = 1'b1;
    rx_dv    = 1'b1;
    rx_byte  = 8'hEE;
    rd_ready = 1'b1;
    tick();
    clr      = 1'b0;
    rx_dv    = 1'b0;
    rd_ready = 1'b0;
    sb.delete();
    checks++;
    if (level !== '0 || overrun !== 1'b0 || rd_valid !== 1'b0 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL clr: level=%0d ovr=%b valid=%b to=%b, want 0 0 0 0", level, overrun, rd_valid, timeout);
    end
    tick();
    checks++;
    if (level !== '0) begin
      errors++;
      $display("FAIL clr_byte_lost: level=%0d, want 0", level);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < DEPTH + 1; i++) push(8'(8'h60 + i));
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    sb.delete();
    checks++;
    if (rd_valid !== 1'b0 || rd_data !== 8'h00 || level !== '0 || overrun !== 1'b0 ||
        timeout !== 1'b0 || wm !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: valid=%b data=%h level=%0d ovr=%b to=%b wm=%b, want all 0",
               rd_valid, rd_data, level, overrun, timeout, wm);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back();
    logic do_pop;
    logic [7:0] b;
    for (int i = 0; i < 60; i++) begin
      rx_dv    = ($urandom_range(0, 99) < 60);
      rd_ready = ($urandom_range(0, 99) < 45);
      b        = 8'($urandom);
      rx_byte  = b;
      do_pop   = rd_ready && (sb.size() > 0);
      if (do_pop) begin
        checks++;
        if (rd_data !== sb[0]) begin
          errors++;
          $display("FAIL wrap_data[%0d]: data=%h, want %h", i, rd_data, sb[0]);
        end
        void'(sb.pop_front());
      end
      if (rx_dv && (sb.size() < DEPTH)) sb.push_back(b);
      tick();
      checks++;
      if (level !== 5'(sb.size()) || rd_valid !== (sb.size() > 0)) begin
        errors++;
        $display("FAIL wrap_level[%0d]: level=%0d valid=%b, want %0d", i, level, rd_valid, sb.size());
      end
    end
    rx_dv    = 1'b0;
    rd_ready = 1'b0;
    while (sb.size() > 0) pop_check("wrap_drain");
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    rst_n        = 1'b0;
    rx_dv        = 1'b0;
    rx_byte      = '0;
    clks_per_bit = 16'd16;
    clr          = 1'b0;
    clr_ovr      = 1'b0;
    wm_level     = '0;
    rd_ready     = 1'b0;
    tick();
    tick();
    test_reset();
    rst_n = 1'b1;
    tick();
    test_reset();
    test_basic();
    test_overrun();
    test_full_push_pop();
    test_timeout();
    test_watermark();
    test_clr();
    test_async_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
